avalon_mm_write_master: RTL and testbench
=========================================

# avalon_mm_write_master

Streaming Avalon-MM write master that drains a user-side FIFO to a contiguous or fixed memory address range. It sits between the on-fabric result generator (pseudo-random operand/DUT result path running on `variable_clk`) and the HPS/SDRAM memory interconnect. It provides a go/done control handshake, a FIFO-backed user write port with full back-pressure, and a pipelined-free single-word Avalon-MM write interface honouring `waitrequest`.

## Interface
- `DATAWIDTH`, 32, data word width in bits
- `BYTEENABLEWIDTH`, 4, bytes per word (DATAWIDTH/8); also the address increment
- `ADDRESSWIDTH`, 32, byte-address and length width
- `FIFODEPTH`, 16384, user FIFO depth in words
- `FIFODEPTH_LOG2`, 14, log2(FIFODEPTH)
- `FIFOUSEMEMORY`, 1, 1 = FIFO storage in block RAM, 0 = registers (no functional difference)

- `variable_clk`  in  1  single clock for all logic
- `reset`  in  1  reset, synchronous, active-high
- `control_fixed_location`  in  1  1 = do not increment address
- `control_write_base`  in  ADDRESSWIDTH  start byte address, sampled on go
- `control_write_length`  in  ADDRESSWIDTH  transfer length in bytes, sampled on go
- `control_go`  in  1  one-cycle start pulse
- `control_done`  out  1  1 when remaining length is 0
- `user_write_buffer`  in  1  push `user_buffer_data` into FIFO
- `user_buffer_data`  in  DATAWIDTH  data to push
- `user_buffer_full`  out  1  FIFO full
- `master_address`  out  ADDRESSWIDTH  current byte address
- `master_write`  out  1  write request
- `master_byteenable`  out  BYTEENABLEWIDTH  constant all ones
- `master_writedata`  out  DATAWIDTH  FIFO head word (show-ahead)
- `master_waitrequest`  in  1  slave stall

## Operation
- Registers: `addr` (ADDRESSWIDTH), `len` (ADDRESSWIDTH), FIFO with read/write pointers and count (FIFODEPTH_LOG2+1 bits).
- `control_go`=1: `addr` <= `control_write_base`, `len` <= `control_write_length` with low log2(BYTEENABLEWIDTH) bits forced to 0. Go is accepted at any time; it overrides an in-progress transfer. FIFO contents are never flushed by go.
- `control_fixed_location` is sampled every cycle (held stable by user during a transfer).
- `master_write` = FIFO non-empty AND `len` != 0. `master_writedata` = FIFO head. `master_address` = `addr`. `master_byteenable` = all ones.
- Accept = `master_write` AND NOT `master_waitrequest`: pop FIFO, `len` <= `len` − BYTEENABLEWIDTH, `addr` <= `addr` + BYTEENABLEWIDTH unless fixed_location. Go in the same cycle as accept wins (reload, no decrement); the pop still occurs.
- `control_done` = (`len` == 0), combinational from register.
- User push: `user_write_buffer`=1 and FIFO not full -> store. Push while full is dropped silently. Push and pop in same cycle on a full FIFO: pop happens, push is dropped (full evaluated on registered count).
- `user_buffer_full` = count == FIFODEPTH.
- Address wraps modulo 2^ADDRESSWIDTH with no error.

## Timing
- Reset values: `addr`=0, `len`=0, `control_done`=1, `master_write`=0, FIFO empty, `user_buffer_full`=0, `master_writedata` undefined-but-stable (don't care while write=0).
- Go at edge N: `control_done` falls after edge N (visible cycle N+1); `master_write` may assert in cycle N+1 if FIFO non-empty.
- Push at edge N: word visible at FIFO head / counts toward empty from cycle N+1 (one-cycle write-to-read latency).
- While `master_waitrequest`=1, address, data, write remain stable.
- Sustained throughput: one word per cycle when FIFO non-empty and no waitrequest.
- `control_done` rises in the cycle after the final accept.
- Reset mid-transfer: all state returns to reset values at the next edge; FIFO emptied.
- `control_write_length`=0 on go: done stays 1, no writes issued.

## Test plan
- Reset -> done=1, master_write=0, full=0, address=0.
- Push 4 words 0xA0..0xA3, go base=0x1000 length=16, waitrequest=0 -> writes at 0x1000,0x1004,0x1008,0x100C with data A0..A3 in consecutive cycles, byteenable=0xF, done=1 one cycle after last.
- Same with waitrequest high 3 cycles on second word -> address/data held at 0x1004/A1 during stall, order unchanged, exactly 4 writes.
- fixed_location=1, base=0x2000, length=12, 3 words -> all writes to 0x2000; length=10 on go behaves as 8 (2 writes).
- Fill FIFO to FIFODEPTH -> full=1; extra push dropped; after one accept full=0 and drained data sequence has no extra word.
- Go with length=0 -> no writes, done remains 1; go mid-transfer with new base 0x3000 length=8 -> next accepted write at 0x3000, exactly 2 further writes.

Source files
------------

// File: rtl/avalon_mm_write_master.sv
// Avalon-MM write master: drains a show-ahead user FIFO to memory
// as single-word writes over a contiguous or fixed address range.
module avalon_mm_write_master #(
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int ADDRESSWIDTH    = 32,
  parameter int FIFODEPTH       = 16384,
  parameter int FIFODEPTH_LOG2  = 14,
  parameter int FIFOUSEMEMORY   = 1
) (
  input  logic                       variable_clk,
  input  logic                       reset,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_write_base,
  input  logic [ADDRESSWIDTH-1:0]    control_write_length,
  input  logic                       control_go,
  output logic                       control_done,
  input  logic                       user_write_buffer,
  input  logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_buffer_full,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_write,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [DATAWIDTH-1:0]       master_writedata,
  input  logic                       master_waitrequest
);

  localparam int PW = FIFODEPTH_LOG2;
  localparam int CW = FIFODEPTH_LOG2 + 1;
  localparam logic [ADDRESSWIDTH-1:0] STEP =
    ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [CW-1:0] DEPTH = CW'(FIFODEPTH);
  localparam logic [PW-1:0] LAST  = PW'(FIFODEPTH - 1);

  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [ADDRESSWIDTH-1:0] len_q, len_d;
  logic [PW-1:0]           wptr_q, wptr_d;
  logic [PW-1:0]           rptr_q, rptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    push, pop, empty;
  logic [DATAWIDTH-1:0]    head;

  assign empty            = (cnt_q == '0);
  assign user_buffer_full = (cnt_q == DEPTH);
  assign push             = user_write_buffer & ~user_buffer_full;
  assign master_write     = ~empty & (len_q != '0);
  assign pop              = master_write & ~master_waitrequest;

  assign control_done      = (len_q == '0);
  assign master_address    = addr_q;
  assign master_byteenable = '1;
  assign master_writedata  = head;

  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    // go reloads even when a word is accepted in the same cycle
    if (control_go) begin
      addr_d = control_write_base;
      len_d  = control_write_length & ~(STEP - 1'b1);
    end else if (pop) begin
      len_d = len_q - STEP;
      if (!control_fixed_location)
        addr_d = addr_q + STEP;
    end
    wptr_d = wptr_q;
    if (push)
      wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
    rptr_d = rptr_q;
    if (pop)
      rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge variable_clk) begin
    if (reset) begin
      addr_q <= '0;
      len_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      len_q  <= len_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  if (FIFOUSEMEMORY != 0) begin : g_ram
    (* ramstyle = "M10K" *)
    logic [DATAWIDTH-1:0] mem [FIFODEPTH];
    always_ff @(posedge variable_clk) begin
      if (push)
        mem[wptr_q] <= user_buffer_data;
    end
    assign head = mem[rptr_q];
  end else begin : g_reg
    (* ramstyle = "logic" *)
    logic [DATAWIDTH-1:0] mem [FIFODEPTH];
    always_ff @(posedge variable_clk) begin
      if (push)
        mem[wptr_q] <= user_buffer_data;
    end
    assign head = mem[rptr_q];
  end

endmodule

// File: tb/tb_avalon_mm_write_master.sv
// Bench for avalon_mm_write_master: vector table, corner sequences
// and random traffic against a queue-based reference model.
module tb_avalon_mm_write_master;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fx = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] blen = '0;
  logic        go = 1'b0;
  logic        done;
  logic        wb = 1'b0;
  logic [31:0] wdata = '0;
  logic        full;
  logic [31:0] maddr;
  logic        mwrite;
  logic [3:0]  mbe;
  logic [31:0] mdata;
  logic        wt = 1'b0;

  avalon_mm_write_master #(
    .FIFODEPTH(DEPTH),
    .FIFODEPTH_LOG2(5)
  ) dut (
    .variable_clk(clk),
    .reset(rst),
    .control_fixed_location(fx),
    .control_write_base(base),
    .control_write_length(blen),
    .control_go(go),
    .control_done(done),
    .user_write_buffer(wb),
    .user_buffer_data(wdata),
    .user_buffer_full(full),
    .master_address(maddr),
    .master_write(mwrite),
    .master_byteenable(mbe),
    .master_writedata(mdata),
    .master_waitrequest(wt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic        rst, go, wb, chk, ew, ed, ef;
    logic [31:0] base, len, data, ea, edat;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mq[$];
  logic [31:0] m_addr = '0;
  logic [31:0] m_len = '0;
  logic        m_valid = 1'b0;
  wr_t         obs[$];

  logic        s_w, s_done, s_full;
  logic [31:0] s_a, s_d;
  logic [3:0]  s_be;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock: sample at negedge, check model, advance model at edge
  task automatic tick();
    logic ew, acc, pok;
    @(negedge clk);
    s_w = mwrite; s_a = maddr; s_d = mdata;
    s_done = done; s_full = full; s_be = mbe;
    ew = (mq.size() != 0) && (m_len != 0);
    if (m_valid) begin
      chk("write", 32'(s_w), 32'(ew));
      chk("done", 32'(s_done), 32'(m_len == 0));
      chk("full", 32'(s_full), 32'(mq.size() == DEPTH));
      chk("addr", s_a, m_addr);
      chk("be", 32'(s_be), 32'hF);
      if (ew) chk("data", s_d, mq[0]);
    end
    if (s_w && !wt) obs.push_back('{a: s_a, d: s_d});
    if (rst) begin
      mq.delete();
      m_addr = '0;
      m_len = '0;
      m_valid = 1'b1;
    end else begin
      acc = ew && !wt;
      pok = wb && (mq.size() < DEPTH);
      if (acc) void'(mq.pop_front());
      if (pok) mq.push_back(wdata);
      if (go) begin
        m_addr = base;
        m_len = blen & ~32'd3;
      end else if (acc) begin
        m_len = m_len - 32'd4;
        if (!fx) m_addr = m_addr + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; go = 1'b0; wb = 1'b0; wt = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic pushw(input logic [31:0] d);
    idle(); wb = 1'b1; wdata = d; tick(); wb = 1'b0;
  endtask

  task automatic dogo(input logic [31:0] b, input logic [31:0] l,
                      input logic f);
    idle(); go = 1'b1; base = b; blen = l; fx = f; tick(); go = 1'b0;
  endtask

  task automatic run(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic vec_t mk(logic r, logic g, logic w,
      logic [31:0] b, logic [31:0] l, logic [31:0] d,
      logic c, logic ew, logic ed, logic [31:0] ea, logic [31:0] edat);
    vec_t v;
    v.rst = r; v.go = g; v.wb = w; v.base = b; v.len = l; v.data = d;
    v.chk = c; v.ew = ew; v.ed = ed; v.ef = 1'b0; v.ea = ea;
    v.edat = edat;
    return v;
  endfunction

  vec_t tv[12];

  initial begin
    tv[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tv[1]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tv[2]  = mk(0, 0, 1, 0, 0, 32'hA0, 1, 0, 1, 0, 0);
    tv[3]  = mk(0, 0, 1, 0, 0, 32'hA1, 1, 0, 1, 0, 0);
    tv[4]  = mk(0, 0, 1, 0, 0, 32'hA2, 1, 0, 1, 0, 0);
    tv[5]  = mk(0, 0, 1, 0, 0, 32'hA3, 1, 0, 1, 0, 0);
    tv[6]  = mk(0, 1, 0, 32'h1000, 16, 0, 1, 0, 1, 0, 0);
    tv[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1000, 32'hA0);
    tv[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1004, 32'hA1);
    tv[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1008, 32'hA2);
    tv[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h100C, 32'hA3);
    tv[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h1010, 0);

    @(posedge clk);
    #1;

    fx = 1'b0;
    for (int i = 0; i < 12; i++) begin
      rst = tv[i].rst; go = tv[i].go; wb = tv[i].wb; wt = 1'b0;
      base = tv[i].base; blen = tv[i].len; wdata = tv[i].data;
      tick();
      if (tv[i].chk) begin
        chk($sformatf("tv%0d_write", i), 32'(s_w), 32'(tv[i].ew));
        chk($sformatf("tv%0d_done", i), 32'(s_done), 32'(tv[i].ed));
        chk($sformatf("tv%0d_full", i), 32'(s_full), 32'(tv[i].ef));
        chk($sformatf("tv%0d_addr", i), s_a, tv[i].ea);
        if (tv[i].ew) chk($sformatf("tv%0d_data", i), s_d, tv[i].edat);
      end
    end

    // stall on the second word
    do_reset();
    for (int i = 0; i < 4; i++) pushw(32'hA0 + 32'(i));
    obs.delete();
    dogo(32'h1000, 16, 1'b0);
    run(1);
    for (int i = 0; i < 3; i++) begin
      idle(); wt = 1'b1; tick();
      chk("stall_write", 32'(s_w), 32'd1);
      chk("stall_addr", s_a, 32'h1004);
      chk("stall_data", s_d, 32'hA1);
    end
    run(5);
    chk("stall_count", 32'(obs.size()), 32'd4);
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      chk("stall_seq_addr", obs[i].a, 32'h1000 + 32'(4 * i));
      chk("stall_seq_data", obs[i].d, 32'hA0 + 32'(i));
    end
    chk("stall_done", 32'(s_done), 32'd1);

    // fixed location, then truncated length
    do_reset();
    for (int i = 0; i < 3; i++) pushw(32'hC0 + 32'(i));
    obs.delete();
    dogo(32'h2000, 12, 1'b1);
    run(5);
    chk("fixed_count", 32'(obs.size()), 32'd3);
    foreach (obs[i]) chk("fixed_addr", obs[i].a, 32'h2000);
    for (int i = 3; i < 6; i++) pushw(32'hC0 + 32'(i));
    obs.delete();
    dogo(32'h2000, 10, 1'b1);
    run(5);
    chk("len10_count", 32'(obs.size()), 32'd2);
    chk("len10_done", 32'(s_done), 32'd1);
    fx = 1'b0;

    // zero length go
    obs.delete();
    dogo(32'h4000, 0, 1'b0);
    run(3);
    chk("len0_count", 32'(obs.size()), 32'd0);
    chk("len0_done", 32'(s_done), 32'd1);

    // go overriding a transfer while a word is accepted
    for (int i = 0; i < 4; i++) pushw(32'hD0 + 32'(i));
    dogo(32'h1000, 64, 1'b0);
    run(2);
    dogo(32'h3000, 8, 1'b0);
    obs.delete();
    run(5);
    chk("rego_count", 32'(obs.size()), 32'd2);
    if (obs.size() == 2) begin
      chk("rego_addr0", obs[0].a, 32'h3000);
      chk("rego_addr1", obs[1].a, 32'h3004);
      chk("rego_data0", obs[0].d, 32'hD2);
    end
    chk("rego_done", 32'(s_done), 32'd1);

    // fill to full, overflow push, push+pop on full
    do_reset();
    for (int i = 0; i < DEPTH; i++) pushw(32'(i));
    run(1);
    chk("full_set", 32'(s_full), 32'd1);
    pushw(32'hDEAD);
    obs.delete();
    dogo(32'h0, 32'(DEPTH * 4), 1'b0);
    pushw(32'hBEEF);
    run(1);
    chk("full_clear", 32'(s_full), 32'd0);
    run(DEPTH + 2);
    chk("drain_count", 32'(obs.size()), 32'(DEPTH));
    foreach (obs[i]) chk("drain_data", obs[i].d, 32'(i));

    // random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      idle();
      rst = ($urandom % 700) == 0;
      go = ($urandom % 40) == 0;
      if (go) begin
        fx = ($urandom % 4) == 0;
        base = (($urandom % 8) == 0) ?
          32'hFFFF_FFF0 + 32'($urandom % 4) * 4 : $urandom;
        blen = 32'($urandom_range(0, 80));
      end
      wb = ($urandom % 3) != 0;
      wdata = $urandom;
      wt = ($urandom % 4) == 0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
